// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (count, LE payload, XOR checksum), writes
// words into program memory and holds the core in reset until the image verifies.
module program_loader #(
   parameter int PROGRAM_MEMORY_DEPTH = 64,
   parameter int DATA_WIDTH           = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  Start_i,
   input  logic                  Byte_Valid_i,
   input  logic [7:0]            Byte_Data_i,
   output logic                  Byte_Ready_o,
   output logic                  Mem_Write_o,
   output logic [31:0]           Mem_Address_o,
   output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
   output logic                  Core_Reset_o,
   output logic                  Done_o,
   output logic                  Error_o
);

   localparam int IDXW = $clog2(PROGRAM_MEMORY_DEPTH + 1);

   typedef enum logic [2:0] {IDLE, HEADER, PAYLOAD, WRITE, CHECK, DONE, ERROR} state_t;

   state_t                state_q, state_d;
   logic [7:0]            count_q, count_d;
   logic [7:0]            csum_q, csum_d;
   logic [IDXW-1:0]       idx_q, idx_d;
   logic [1:0]            bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic                  ready_q, write_q, core_rst_q, done_q, err_q;
   logic [31:0]           addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  accept, restart;

   assign accept = Byte_Valid_i && ready_q;

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      csum_d  = csum_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      restart = 1'b0;
      case (state_q)
         IDLE, DONE, ERROR: restart = Start_i;
         HEADER: if (accept) begin
            count_d = Byte_Data_i;
            csum_d  = csum_q ^ Byte_Data_i;
            if (Byte_Data_i == 8'd0 || int'(Byte_Data_i) > PROGRAM_MEMORY_DEPTH) state_d = ERROR;
            else                                                                 state_d = PAYLOAD;
         end
         PAYLOAD: if (accept) begin
            word_d[8*bcnt_q +: 8] = Byte_Data_i;
            csum_d = csum_q ^ Byte_Data_i;
            bcnt_d = bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) state_d = WRITE;
         end
         WRITE: begin
            idx_d   = idx_q + 1'b1;
            state_d = (int'(idx_q) + 1 == int'(count_q)) ? CHECK : PAYLOAD;
         end
         CHECK: if (accept) state_d = (Byte_Data_i == csum_q) ? DONE : ERROR;
         default: state_d = IDLE;
      endcase
      if (restart) begin
         state_d = HEADER;
         idx_d   = '0;
         bcnt_d  = '0;
         csum_d  = '0;
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         count_q    <= '0;
         csum_q     <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         word_q     <= '0;
         ready_q    <= 1'b0;
         write_q    <= 1'b0;
         core_rst_q <= 1'b1;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         csum_q     <= csum_d;
         idx_q      <= idx_d;
         bcnt_q     <= bcnt_d;
         word_q     <= word_d;
         ready_q    <= (state_d == HEADER) || (state_d == PAYLOAD) || (state_d == CHECK);
         write_q    <= (state_d == WRITE);
         core_rst_q <= (state_d != DONE);
         done_q     <= (state_d == DONE);
         err_q      <= (state_d == ERROR);
         if (state_d == WRITE) begin
            addr_q <= {{(32-IDXW-2){1'b0}}, idx_q, 2'b00};
            data_q <= word_d;
         end
      end
   end

   assign Byte_Ready_o     = ready_q;
   assign Mem_Write_o      = write_q;
   assign Mem_Address_o    = addr_q;
   assign Mem_Write_Data_o = data_q;
   assign Core_Reset_o     = core_rst_q;
   assign Done_o           = done_q;
   assign Error_o          = err_q;

endmodule
